// File: rtl/core.sv
`default_nettype none
// ============================================================================
//  Module   : core
//  Single-cycle RV32I core with a flat machine-mode CSR file and a unified
//  instruction/data word memory.
//  Revision : 1.0
// ============================================================================

module core_mem #(
   parameter int MEM_WORDS = 65536,
   parameter int AW        = 16
) (
   input  logic          clk,
   input  logic [AW-1:0] i_iaddr,
   output logic [31:0]   o_idata,
   input  logic [AW-1:0] i_daddr,
   output logic [31:0]   o_rdata,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata
);
   logic [31:0] m [0:MEM_WORDS-1];

   assign o_idata = m[i_iaddr];
   assign o_rdata = m[i_daddr];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_be[i]) m[i_daddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
   end
endmodule

module core #(
   parameter int          MEM_WORDS = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic clk,
   input  logic rst
);
   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [6:0] c_LUI    = 7'b0110111;
   localparam logic [6:0] c_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_JAL    = 7'b1101111;
   localparam logic [6:0] c_JALR   = 7'b1100111;
   localparam logic [6:0] c_BRANCH = 7'b1100011;
   localparam logic [6:0] c_LOAD   = 7'b0000011;
   localparam logic [6:0] c_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OP     = 7'b0110011;
   localparam logic [6:0] c_SYSTEM = 7'b1110011;

   logic [31:0] pc;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   logic [31:0] w_instr, w_rdata, w_a, w_b, w_pc4, w_daddr, w_ld;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_csr_old, w_csr_src;
   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [11:0] w_csr_a;
   logic [1:0]  w_off;

   logic [31:0] w_npc, w_wb, w_wdata, w_csr_wv, w_cause;
   logic [3:0]  w_be;
   logic        w_wb_en, w_csr_we, w_trap, w_taken;
   logic        w_unused;

   function automatic logic [31:0] f_alu(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  f_alu = alt ? a - b : a + b;
         3'b001:  f_alu = a << b[4:0];
         3'b010:  f_alu = {31'b0, $signed(a) < $signed(b)};
         3'b011:  f_alu = {31'b0, a < b};
         3'b100:  f_alu = a ^ b;
         3'b101:  f_alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  f_alu = a | b;
         default: f_alu = a & b;
      endcase
   endfunction

   assign w_opc   = w_instr[6:0];
   assign w_rd    = w_instr[11:7];
   assign w_f3    = w_instr[14:12];
   assign w_rs1   = w_instr[19:15];
   assign w_rs2   = w_instr[24:20];
   assign w_csr_a = w_instr[31:20];

   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_u = {w_instr[31:12], 12'b0};
   assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

   assign w_a       = (w_rs1 == 5'd0) ? 32'd0 : rs[w_rs1];
   assign w_b       = (w_rs2 == 5'd0) ? 32'd0 : rs[w_rs2];
   assign w_pc4     = pc + 32'd4;
   assign w_daddr   = w_a + ((w_opc == c_STORE) ? w_imm_s : w_imm_i);
   assign w_off     = w_daddr[1:0];
   assign w_ld      = w_rdata >> {w_off, 3'b000};
   assign w_csr_old = csr[w_csr_a];
   assign w_csr_src = w_f3[2] ? {27'b0, w_rs1} : w_a;
   assign w_unused  = ^{w_daddr[31:AW+2]};

   always_comb begin
      w_npc    = w_pc4;
      w_wb_en  = 1'b0;
      w_wb     = 32'd0;
      w_be     = 4'b0000;
      w_wdata  = w_b << {w_off, 3'b000};
      w_csr_we = 1'b0;
      w_csr_wv = w_csr_src;
      w_trap   = 1'b0;
      w_cause  = 32'd0;
      w_taken  = 1'b0;
      case (w_opc)
         c_LUI:   begin w_wb_en = 1'b1; w_wb = w_imm_u; end
         c_AUIPC: begin w_wb_en = 1'b1; w_wb = pc + w_imm_u; end
         c_JAL:   begin w_wb_en = 1'b1; w_wb = w_pc4; w_npc = pc + w_imm_j; end
         c_JALR:  begin w_wb_en = 1'b1; w_wb = w_pc4; w_npc = (w_a + w_imm_i) & ~32'd1; end
         c_BRANCH: begin
            case (w_f3)
               3'b000:  w_taken = (w_a == w_b);
               3'b001:  w_taken = (w_a != w_b);
               3'b100:  w_taken = ($signed(w_a) < $signed(w_b));
               3'b101:  w_taken = ($signed(w_a) >= $signed(w_b));
               3'b110:  w_taken = (w_a < w_b);
               3'b111:  w_taken = (w_a >= w_b);
               default: w_taken = 1'b0;
            endcase
            if (w_taken) w_npc = pc + w_imm_b;
         end
         c_LOAD: begin
            w_wb_en = 1'b1;
            case (w_f3)
               3'b000:  w_wb = {{24{w_ld[7]}}, w_ld[7:0]};
               3'b001:  w_wb = {{16{w_ld[15]}}, w_ld[15:0]};
               3'b100:  w_wb = {24'b0, w_ld[7:0]};
               3'b101:  w_wb = {16'b0, w_ld[15:0]};
               default: w_wb = w_ld;
            endcase
         end
         // Lanes pushed past byte 3 by a misaligned offset are simply dropped.
         c_STORE: begin
            case (w_f3)
               3'b000:  w_be = 4'b0001 << w_off;
               3'b001:  w_be = 4'b0011 << w_off;
               3'b010:  w_be = 4'b1111 << w_off;
               default: w_be = 4'b0000;
            endcase
         end
         c_OPIMM: begin
            w_wb_en = 1'b1;
            w_wb    = f_alu(w_f3, (w_f3 == 3'b101) && w_instr[30], w_a, w_imm_i);
         end
         c_OP: begin
            w_wb_en = 1'b1;
            w_wb    = f_alu(w_f3, w_instr[30], w_a, w_b);
         end
         c_SYSTEM: begin
            if (w_f3 == 3'b000) begin
               case (w_csr_a)
                  12'h000: begin w_trap = 1'b1; w_cause = 32'd11; w_npc = csr[12'h305]; end
                  12'h001: begin w_trap = 1'b1; w_cause = 32'd3;  w_npc = csr[12'h305]; end
                  12'h302: w_npc = csr[12'h341];
                  default: ;
               endcase
            end else begin
               w_wb_en = 1'b1;
               w_wb    = w_csr_old;
               case (w_f3[1:0])
                  2'b01: begin w_csr_we = 1'b1; w_csr_wv = w_csr_src; end
                  2'b10: begin w_csr_we = (w_rs1 != 5'd0); w_csr_wv = w_csr_old | w_csr_src; end
                  2'b11: begin w_csr_we = (w_rs1 != 5'd0); w_csr_wv = w_csr_old & ~w_csr_src; end
                  default: w_wb_en = 1'b0;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++)   rs[i]  <= 32'd0;
         for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
      end else begin
         pc <= w_npc;
         if (w_wb_en && (w_rd != 5'd0)) rs[w_rd] <= w_wb;
         if (w_csr_we) csr[w_csr_a] <= w_csr_wv;
         if (w_trap) begin
            csr[12'h341] <= pc;
            csr[12'h342] <= w_cause;
         end
      end
   end

   // Stores are held off while reset is low so a stale fetch cannot corrupt memory.
   core_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) memory (
      .clk     (clk),
      .i_iaddr (pc[AW+1:2]),
      .o_idata (w_instr),
      .i_daddr (w_daddr[AW+1:2]),
      .o_rdata (w_rdata),
      .i_be    (w_be & {4{rst}}),
      .i_wdata (w_wdata)
   );
endmodule

`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core
//  Self-checking bench for core: vector table, random ALU/branch vectors and
//  hand-written program sequences.
//  Revision : 1.0
// ============================================================================

module tb_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   core #(.MEM_WORDS(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

   int tests = 0;
   int fails = 0;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SLT = 3, OP_SLTU = 4;
   localparam int OP_XOR = 5, OP_SRL = 6, OP_SRA = 7, OP_OR = 8, OP_AND = 9;
   localparam int OP_BEQ = 10, OP_BNE = 11, OP_BLT = 12, OP_BGE = 13, OP_BLTU = 14, OP_BGEU = 15;

   typedef struct {
      int          kind;   // 0 reg-reg, 1 reg-imm, 2 branch
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;    // x3 result, or pc after the branch
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] prog[$];

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int opc);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
      return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, int opc);
      return {imm20[19:0], rd[4:0], opc[6:0]};
   endfunction
   function automatic logic [31:0] enc_j(int off, int rd);
      return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 'h13);
   endfunction

   // Reference model: instruction meaning by mnemonic, independent of encoding.
   function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
      int unsigned sh = b % 32;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLL:  return a << sh;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_XOR:  return a ^ b;
         OP_SRL:  return a >> sh;
         OP_SRA:  return $unsigned($signed(a) >>> sh);
         OP_OR:   return a | b;
         default: return a & b;
      endcase
   endfunction
   function automatic bit ref_taken(int op, logic [31:0] a, logic [31:0] b);
      case (op)
         OP_BEQ:  return a == b;
         OP_BNE:  return a != b;
         OP_BLT:  return $signed(a) < $signed(b);
         OP_BGE:  return $signed(a) >= $signed(b);
         OP_BLTU: return a < b;
         default: return a >= b;
      endcase
   endfunction
   function automatic int op_f3(int op);
      case (op)
         OP_ADD, OP_SUB, OP_BEQ: return 0;
         OP_SLL, OP_BNE:         return 1;
         OP_SLT:                 return 2;
         OP_SLTU:                return 3;
         OP_XOR, OP_BLT:         return 4;
         OP_SRL, OP_SRA, OP_BGE: return 5;
         OP_OR, OP_BLTU:         return 6;
         default:                return 7;
      endcase
   endfunction
   function automatic vec_t mkv(int kind, int op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
      vec_t v;
      v.kind = kind; v.op = op; v.a = a; v.b = b; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic li(input int rd, input logic [31:0] val);
      logic [31:0] hi;
      hi = (val + 32'h800) >> 12;
      prog.push_back(enc_u(hi, rd, 'h37));
      prog.push_back(addi(rd, rd, val));
   endtask

   // Holds reset while loading the program, then runs n clock edges.
   task automatic run_prog(input int n);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) dut.memory.m[i] = 32'd0;
      for (int i = 0; i < prog.size(); i++) dut.memory.m[i] = prog[i];
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int imm;
      prog.delete();
      li(1, v.a);
      li(2, v.b);
      if (v.kind == 0) begin
         prog.push_back(enc_r((v.op == OP_SUB || v.op == OP_SRA) ? 'h20 : 0, 2, 1, op_f3(v.op), 3));
      end else if (v.kind == 1) begin
         if (v.op == OP_SLL || v.op == OP_SRL || v.op == OP_SRA)
            imm = ((v.op == OP_SRA) ? 'h400 : 0) | int'(v.b[4:0]);
         else
            imm = int'(v.b[11:0]);
         prog.push_back(enc_i(imm, 1, op_f3(v.op), 3, 'h13));
      end else begin
         prog.push_back(enc_b(8, 2, 1, op_f3(v.op)));
      end
      prog.push_back(enc_j(0, 0));
      prog.push_back(enc_j(0, 0));
      run_prog(5);
      if (v.kind == 2) chk($sformatf("vec%0d_branch_op%0d_pc", idx, v.op), dut.pc, v.exp);
      else             chk($sformatf("vec%0d_k%0d_op%0d_x3", idx, v.kind, v.op), dut.rs[3], v.exp);
   endtask

   initial begin
      int          bad;
      int          cyc;
      logic [31:0] w;
      logic [11:0] t;
      vec_t        v;

      // ---------------- reset ----------------
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      bad = 0;
      for (int i = 1; i < 32; i++) if (dut.rs[i] !== 32'd0) bad++;
      chk("reset_pc", dut.pc, 32'h0);
      chk("reset_rs_nonzero_count", bad, 0);
      chk("reset_mtvec", dut.csr[12'h305], 32'h0);
      chk("reset_mepc", dut.csr[12'h341], 32'h0);
      for (int i = 0; i < 4; i++) dut.memory.m[i] = 32'd0;
      dut.memory.m[0] = addi(1, 0, 7);
      rst = 1'b1;
      @(negedge clk);
      chk("first_fetch_pc", dut.pc, 32'h4);
      chk("first_fetch_x1", dut.rs[1], 32'd7);

      // ---------------- vector table ----------------
      vecs.push_back(mkv(0, OP_ADD,  32'hFFFFFFFB, 32'h3,        32'hFFFFFFFE));
      vecs.push_back(mkv(0, OP_SUB,  32'h0,        32'h1,        32'hFFFFFFFF));
      vecs.push_back(mkv(0, OP_SLL,  32'h1,        32'd31,       32'h80000000));
      vecs.push_back(mkv(0, OP_SLL,  32'h1,        32'h21,       32'h2));
      vecs.push_back(mkv(0, OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1));
      vecs.push_back(mkv(0, OP_SLTU, 32'h3,        32'hFFFFFFFB, 32'h1));
      vecs.push_back(mkv(0, OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0));
      vecs.push_back(mkv(0, OP_SRL,  32'h80000000, 32'h4,        32'h08000000));
      vecs.push_back(mkv(0, OP_SRA,  32'h80000000, 32'h4,        32'hF8000000));
      vecs.push_back(mkv(0, OP_OR,   32'h12340000, 32'h00005678, 32'h12345678));
      vecs.push_back(mkv(0, OP_AND,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000));
      vecs.push_back(mkv(1, OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000));
      vecs.push_back(mkv(1, OP_SLT,  32'h5,        32'hFFFFF800, 32'h0));
      vecs.push_back(mkv(1, OP_SLTU, 32'h5,        32'hFFFFFFFF, 32'h1));
      vecs.push_back(mkv(1, OP_XOR,  32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000));
      vecs.push_back(mkv(1, OP_SRA,  32'hFFFFFFFB, 32'h1,        32'hFFFFFFFD));
      vecs.push_back(mkv(2, OP_BEQ,  32'h5,        32'h5,        32'h18));
      vecs.push_back(mkv(2, OP_BNE,  32'h5,        32'h5,        32'h14));
      vecs.push_back(mkv(2, OP_BLT,  32'hFFFFFFFF, 32'h1,        32'h18));
      vecs.push_back(mkv(2, OP_BGE,  32'h1,        32'hFFFFFFFF, 32'h18));
      vecs.push_back(mkv(2, OP_BLTU, 32'hFFFFFFFF, 32'h1,        32'h14));
      vecs.push_back(mkv(2, OP_BGEU, 32'hFFFFFFFF, 32'h1,        32'h18));

      // ---------------- random vectors vs. reference model ----------------
      for (int i = 0; i < 40; i++) begin
         v.kind = int'($urandom_range(0, 2));
         v.a    = $urandom;
         if (v.kind == 0) begin
            v.op  = int'($urandom_range(0, 9));
            v.b   = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
            v.exp = ref_alu(v.op, v.a, v.b);
         end else if (v.kind == 1) begin
            v.op = int'($urandom_range(0, 9));
            if (v.op == OP_SUB) v.op = OP_ADD;
            if (v.op == OP_SLL || v.op == OP_SRL || v.op == OP_SRA) begin
               v.b = $urandom_range(0, 31);
            end else begin
               t   = 12'($urandom);
               v.b = {{20{t[11]}}, t};
            end
            v.exp = ref_alu(v.op, v.a, v.b);
         end else begin
            v.op  = int'($urandom_range(10, 15));
            v.b   = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
            v.exp = ref_taken(v.op, v.a, v.b) ? 32'h18 : 32'h14;
         end
         vecs.push_back(v);
      end
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // ---------------- arithmetic program ----------------
      prog.delete();
      prog.push_back(addi(1, 0, -5));
      prog.push_back(addi(2, 0, 3));
      prog.push_back(enc_r(0, 2, 1, 0, 3));
      prog.push_back(enc_r(0, 1, 2, 3, 4));
      prog.push_back(enc_i('h401, 1, 5, 5, 'h13));
      prog.push_back(enc_j(0, 0));
      run_prog(5);
      chk("arith_x3", dut.rs[3], 32'hFFFFFFFE);
      chk("arith_x4", dut.rs[4], 32'h1);
      chk("arith_x5", dut.rs[5], 32'hFFFFFFFD);

      // ---------------- branch sequence ----------------
      prog.delete();
      prog.push_back(addi(1, 0, -1));
      prog.push_back(addi(2, 0, 1));
      prog.push_back(enc_b(8, 2, 1, 4));     // 0x08 blt  -> 0x10
      prog.push_back(addi(10, 0, 1));
      prog.push_back(enc_b(8, 2, 1, 6));     // 0x10 bltu falls through
      prog.push_back(enc_b(8, 1, 2, 5));     // 0x14 bge  -> 0x1c
      prog.push_back(addi(11, 0, 1));
      prog.push_back(enc_j(0, 0));
      run_prog(3);
      chk("blt_target", dut.pc, 32'h10);
      @(negedge clk);
      chk("bltu_fallthrough", dut.pc, 32'h14);
      @(negedge clk);
      chk("bge_target", dut.pc, 32'h1c);
      chk("branch_skip_x10", dut.rs[10], 32'h0);
      chk("branch_skip_x11", dut.rs[11], 32'h0);

      // ---------------- load / store ----------------
      prog.delete();
      li(1, 32'h80402010);
      prog.push_back(addi(2, 0, 'hAB));
      prog.push_back(addi(5, 0, 'h100));
      prog.push_back(enc_s(0, 1, 5, 2));                 // sw  x1,0(x5)
      prog.push_back(enc_s(1, 2, 5, 0));                 // sb  x2,1(x5)
      prog.push_back(enc_i(0, 5, 2, 6, 'h03));           // lw  x6,0(x5)
      prog.push_back(enc_i(1, 5, 0, 7, 'h03));           // lb  x7,1(x5)
      prog.push_back(enc_i(2, 5, 5, 8, 'h03));           // lhu x8,2(x5)
      prog.push_back(enc_u('h40, 9, 'h37));              // lui x9,0x40
      prog.push_back(enc_r(0, 5, 9, 0, 9));              // add x9,x9,x5
      prog.push_back(enc_i(0, 9, 2, 10, 'h03));          // lw  x10,0(x9) aliased
      prog.push_back(enc_i(2, 5, 1, 11, 'h03));          // lh  x11,2(x5)
      prog.push_back(enc_s(7, 2, 5, 1));                 // sh  x2,7(x5) misaligned
      prog.push_back(enc_j(0, 0));
      run_prog(14);
      chk("ls_mem_word", dut.memory.m[64], 32'h8040AB10);
      chk("ls_lw", dut.rs[6], 32'h8040AB10);
      chk("ls_lb", dut.rs[7], 32'hFFFFFFAB);
      chk("ls_lhu", dut.rs[8], 32'h00008040);
      chk("ls_alias_lw", dut.rs[10], 32'h8040AB10);
      chk("ls_lh", dut.rs[11], 32'hFFFF8040);
      chk("ls_sh_lane3", dut.memory.m[65], 32'hAB000000);

      // ---------------- CSR and trap ----------------
      prog.delete();
      prog.push_back(enc_j(16, 0));                      // 0x00 -> 0x10
      prog.push_back(32'h30200073);                      // 0x04 mret
      prog.push_back(32'h0);
      prog.push_back(32'h0);
      prog.push_back(addi(1, 0, 4));                     // 0x10
      prog.push_back(enc_i('h305, 1, 1, 0, 'h73));       // csrrw  x0,mtvec,x1
      prog.push_back(enc_i('h305, 1, 1, 6, 'h73));       // csrrw  x6,mtvec,x1
      prog.push_back(enc_i('h340, 5, 6, 8, 'h73));       // csrrsi x8,mscratch,5
      prog.push_back(enc_i('h340, 1, 3, 9, 'h73));       // csrrc  x9,mscratch,x1
      prog.push_back(enc_j(12, 0));                      // 0x24 -> 0x30
      prog.push_back(32'h0);
      prog.push_back(32'h0);
      prog.push_back(32'h00000073);                      // 0x30 ecall
      run_prog(8);
      chk("ecall_pc", dut.pc, 32'h4);
      chk("ecall_mepc", dut.csr[12'h341], 32'h30);
      chk("ecall_mcause", dut.csr[12'h342], 32'd11);
      chk("csrrw_old", dut.rs[6], 32'h4);
      chk("csrrsi_old", dut.rs[8], 32'h0);
      chk("csrrc_old", dut.rs[9], 32'h5);
      chk("mscratch", dut.csr[12'h340], 32'h1);
      @(negedge clk);
      chk("mret_pc", dut.pc, 32'h30);
      dut.memory.m[12] = 32'h00100073;
      @(negedge clk);
      chk("ebreak_pc", dut.pc, 32'h4);
      chk("ebreak_mcause", dut.csr[12'h342], 32'd3);

      // ---------------- blt compliance-style program ----------------
      prog.delete();
      prog.push_back(addi(3, 0, 2));
      prog.push_back(addi(1, 0, -1));
      prog.push_back(addi(2, 0, 1));
      prog.push_back(enc_b(8, 2, 1, 4));
      prog.push_back(enc_j('h28, 0));
      prog.push_back(addi(3, 0, 3));
      prog.push_back(enc_b('h20, 1, 2, 4));
      prog.push_back(addi(3, 0, 4));
      prog.push_back(enc_b('h18, 1, 1, 4));
      prog.push_back(addi(0, 0, 5));
      prog.push_back(addi(3, 0, 5));
      prog.push_back(enc_b('h14, 2, 0, 4));
      prog.push_back(enc_j(8, 0));
      prog.push_back(32'h0);
      prog.push_back(enc_j(0, 0));                       // 0x38 fail loop
      prog.push_back(32'h0);
      prog.push_back(addi(3, 0, 1));                     // 0x40
      prog.push_back(enc_j(0, 0));                       // 0x44 pass loop
      run_prog(0);
      cyc = 0;
      while (cyc < 5000 && dut.pc !== 32'h44) begin
         @(negedge clk);
         cyc++;
      end
      chk("blt_reach_pass_pc", dut.pc, 32'h44);
      chk("blt_gp", dut.rs[3], 32'h1);
      chk("x0_stays_zero", dut.rs[0], 32'h0);

      // ---------------- asynchronous reset mid-program ----------------
      w = prog[16];
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset_pc", dut.pc, 32'h0);
      chk("midreset_x3", dut.rs[3], 32'h0);
      chk("midreset_mem_kept", dut.memory.m[16], w);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("restart_pc", dut.pc, 32'h4);
      chk("restart_x3", dut.rs[3], 32'h2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
